bsg_clk_gen_pearl_tag_sequencer: RTL and testbench
==================================================

Name: bsg_clk_gen_pearl_tag_sequencer

Overview:
- Replaces the bench-side tag driver in the clock-generator PCB harness.
- Accepts configuration commands (node id, data_not_reset, length, payload) over a valid/ready interface and serializes each one into a bsg_tag packet on tag_clk_o/tag_data_o/tag_en_o.
- Generates the tag clock itself by dividing clk_i.
- After reset, sends a zero flush, then a fixed inter-packet gap after every packet, so the clock generator's tag clients are configured in order.

Parameters:
- tag_els_p, 6: number of tag clients. id_width_lp = `BSG_SAFE_CLOG2(tag_els_p) (3 at default).
- tag_max_payload_width_p, 7: maximum payload bits. len_width_lp = `BSG_SAFE_CLOG2(tag_max_payload_width_p+1) (3 at default).
- clk_div_p, 2: tag_clk_o half-period in clk_i cycles. Must be at least 1. One bit slot = 2*clk_div_p cycles.
- flush_bits_p, 16: number of zero bit slots sent after reset.
- gap_bits_p, 2: number of zero bit slots sent after every packet.

Ports:
- clk_i, in, 1: single clock.
- reset_n_i, in, 1: reset, synchronous, active-low.
- v_i, in, 1: command valid.
- ready_o, out, 1: command ready. A command transfers when v_i & ready_o.
- node_id_i, in, id_width_lp: target client.
- data_not_reset_i, in, 1: 1 = data packet, 0 = client reset packet.
- len_i, in, len_width_lp: number of payload bits.
- payload_i, in, tag_max_payload_width_p: payload, bit 0 sent first.
- tag_clk_o, out, 1: divided tag clock.
- tag_data_o, out, 1: serial tag data.
- tag_en_o, out, 1: tag enable.
- busy_o, out, 1: 1 whenever the state is not IDLE.
- err_o, out, 1: one-cycle pulse when a command is dropped.

Behaviour:
- Reset (reset_n_i=0 at a clk_i edge) forces:
  - tag_clk_o=0, tag_data_o=0, tag_en_o=0, ready_o=0, busy_o=1, err_o=0;
  - state=FLUSH, divider counter=0, slot counter=0.
- Reset asserted mid-packet aborts the packet immediately. The next packet is preceded by a full flush.
- Divider:
  - Counts 0..clk_div_p-1 and toggles tag_clk_o at the wrap.
  - Free-runs in every state except reset.
  - A slot start is the cycle tag_clk_o goes 1->0. The first slot after reset starts with the first cycle out of reset, with tag_clk_o low.
  - tag_data_o changes only at slot starts, so it is stable across every tag_clk_o rising edge.
- tag_en_o goes to 1 on the first cycle out of reset and stays 1 until the next reset.
- States:
  - FLUSH: tag_data_o=0 for flush_bits_p slots, then IDLE.
  - IDLE: ready_o=1, tag_data_o=0. On handshake, latch the packet into a shift register and go to ARM. If len_i > tag_max_payload_width_p, drop the command, pulse err_o the next cycle and stay in IDLE.
  - ARM: ready_o=0. Wait for the next slot start, then go to SHIFT.
  - SHIFT: drive one bit per slot, total nbits = 1 + id_width_lp + 1 + len_width_lp + len. After the last slot, go to GAP.
  - GAP: tag_data_o=0 for gap_bits_p slots, then IDLE. If gap_bits_p=0, go straight to IDLE.
- Packet bit order, each field LSB first:
  - start bit 1;
  - node_id;
  - data_not_reset;
  - len;
  - payload[len-1:0].
- Payload bits at or above len are never sent.
- len=0 is legal: a header-only packet.
- Latency: the start bit appears on tag_data_o at the first slot start strictly after the handshake cycle, i.e. 1 to 2*clk_div_p cycles later.
- Slot counter width covers max(flush_bits_p, nbits_max, gap_bits_p).
- Back-to-back commands: ready_o returns to 1 exactly gap_bits_p slots after the last packet bit. v_i held high continuously produces packets separated by exactly gap_bits_p zero slots, plus the ARM alignment wait.
- v_i while ready_o=0 has no effect. The command inputs are sampled only in the handshake cycle.

Decomposition:
- Shared package bsg_clk_gen_pearl_pkg holds:
  - a typedef for the sequencer state enum (FLUSH, IDLE, ARM, SHIFT, GAP);
  - a packed struct typedef for the command {node_id, data_not_reset, len, payload}, parameterized through the width localparams computed by the user;
  - the existing constant bsg_clk_gen_pearl_tag_local_els_gp, used by the harness for tag_els_p defaults.
- One sub-module: bsg_clk_gen_pearl_tag_clk_div. It contains the divider counter and tag_clk_o, and outputs slot_start_o as a one-cycle pulse.

Test Plan:
- Reset, then release with clk_div_p=2 -> tag_en_o=1 next cycle. Exactly 16 slots (64 cycles) of tag_data_o=0, then ready_o=1. tag_clk_o period is 4 cycles.
- Command node_id=5, data_not_reset=1, len=7, payload=7'h55 -> 15 bits sampled on tag_clk_o rising edges: 1, 101, 1, 111, 1010101 (LSB first). Then 2 zero slots, then ready_o=1.
- Command node_id=2, data_not_reset=0, len=0 -> 8-bit header only: 1, 010, 0, 000. busy_o falls 2 slots after the last bit.
- len_i=7 accepted but len_i invalid at a reduced tag_max_payload_width_p=5 (len=6) -> err_o pulses once, no tag_data_o activity, ready_o stays 1.
- v_i held high with 3 queued commands -> three packets with exactly 2 zero slots between each, and tag_data_o never changing while tag_clk_o is high.
- reset_n_i=0 during SHIFT bit 4 -> next cycle tag_data_o=0, tag_en_o=0, tag_clk_o=0. After release, a full 16-slot flush occurs before ready_o=1.

Source files
------------

// File: rtl/bsg_clk_gen_pearl_pkg.sv
// Shared types and constants for the clock-generator pearl tag sequencer.
// Imported by the sequencer top and its tag clock divider.
package bsg_clk_gen_pearl_pkg;

  localparam int bsg_clk_gen_pearl_tag_local_els_gp = 6;

  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  localparam int tag_payload_width_gp = 7;
  localparam int tag_id_width_gp =
    safe_clog2(bsg_clk_gen_pearl_tag_local_els_gp);
  localparam int tag_len_width_gp =
    safe_clog2(tag_payload_width_gp + 1);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_ARM,
    S_SHIFT,
    S_GAP
  } tag_state_e;

  typedef struct packed {
    logic [tag_id_width_gp-1:0]     node_id;
    logic                           data_not_reset;
    logic [tag_len_width_gp-1:0]    len;
    logic [tag_payload_width_gp-1:0] payload;
  } tag_cmd_s;

endpackage

// File: rtl/bsg_clk_gen_pearl_tag_clk_div.sv
// Free-running tag clock divider; slot_start_o marks the last cycle of
// each bit slot so registered data changes with the tag_clk falling edge.
module bsg_clk_gen_pearl_tag_clk_div
  import bsg_clk_gen_pearl_pkg::*;
#(
  parameter int clk_div_p = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  output logic tag_clk_o,
  output logic slot_start_o
);

  localparam int cw_lp = safe_clog2(clk_div_p);
  localparam logic [cw_lp-1:0] last_lp = cw_lp'(clk_div_p - 1);

  logic [cw_lp-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == last_lp);
  assign slot_start_o = wrap & tag_clk_o;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt       <= '0;
      tag_clk_o <= 1'b0;
    end else if (wrap) begin
      cnt       <= '0;
      tag_clk_o <= ~tag_clk_o;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_clk_gen_pearl_tag_sequencer.sv
// Serializes tag configuration commands into bsg_tag packets with a
// self-generated tag clock, reset flush and fixed inter-packet gap.
module bsg_clk_gen_pearl_tag_sequencer
  import bsg_clk_gen_pearl_pkg::*;
#(
  parameter int tag_els_p = bsg_clk_gen_pearl_tag_local_els_gp,
  parameter int tag_max_payload_width_p = 7,
  parameter int clk_div_p = 2,
  parameter int flush_bits_p = 16,
  parameter int gap_bits_p = 2,
  localparam int id_width_lp = safe_clog2(tag_els_p),
  localparam int len_width_lp = safe_clog2(tag_max_payload_width_p + 1)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               v_i,
  output logic                               ready_o,
  input  logic [id_width_lp-1:0]             node_id_i,
  input  logic                               data_not_reset_i,
  input  logic [len_width_lp-1:0]            len_i,
  input  logic [tag_max_payload_width_p-1:0] payload_i,
  output logic                               tag_clk_o,
  output logic                               tag_data_o,
  output logic                               tag_en_o,
  output logic                               busy_o,
  output logic                               err_o
);

  localparam int hdr_bits_lp = 2 + id_width_lp + len_width_lp;
  localparam int nbits_max_lp = hdr_bits_lp + tag_max_payload_width_p;
  localparam int m1_lp = (flush_bits_p > nbits_max_lp)
                         ? flush_bits_p : nbits_max_lp;
  localparam int slot_max_lp = (m1_lp > gap_bits_p) ? m1_lp : gap_bits_p;
  localparam int cw_lp = safe_clog2(slot_max_lp + 1);

  localparam logic [cw_lp-1:0] flush_last_lp =
    cw_lp'((flush_bits_p > 0) ? flush_bits_p - 1 : 0);
  localparam logic [cw_lp-1:0] gap_last_lp =
    cw_lp'((gap_bits_p > 0) ? gap_bits_p - 1 : 0);
  localparam logic [cw_lp-1:0] hdr_last_lp = cw_lp'(hdr_bits_lp - 1);
  localparam logic [len_width_lp:0] len_max_lp =
    (len_width_lp + 1)'(tag_max_payload_width_p);

  tag_state_e               state;
  logic [cw_lp-1:0]         cnt;
  logic [nbits_max_lp-1:0]  sr;
  logic [nbits_max_lp-1:0]  pkt;
  logic                     slot_start;
  logic                     len_bad;

  bsg_clk_gen_pearl_tag_clk_div #(
    .clk_div_p(clk_div_p)
  ) clk_div (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .tag_clk_o   (tag_clk_o),
    .slot_start_o(slot_start)
  );

  // Start bit sits at bit 0 so the packet leaves LSB first.
  assign pkt = {payload_i, len_i, data_not_reset_i, node_id_i, 1'b1};
  assign len_bad = {1'b0, len_i} > len_max_lp;

  assign ready_o = (state == S_IDLE);
  assign busy_o  = (state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state      <= S_FLUSH;
      cnt        <= '0;
      sr         <= '0;
      tag_data_o <= 1'b0;
      tag_en_o   <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      tag_en_o <= 1'b1;
      err_o    <= 1'b0;
      unique case (state)
        S_FLUSH: if (slot_start) begin
          if (cnt == flush_last_lp) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_IDLE: if (v_i) begin
          if (len_bad) begin
            err_o <= 1'b1;
          end else begin
            cnt <= hdr_last_lp + cw_lp'(len_i);
            if (slot_start) begin
              state      <= S_SHIFT;
              tag_data_o <= pkt[0];
              sr         <= pkt >> 1;
            end else begin
              state <= S_ARM;
              sr    <= pkt;
            end
          end
        end
        S_ARM: if (slot_start) begin
          state      <= S_SHIFT;
          tag_data_o <= sr[0];
          sr         <= sr >> 1;
        end
        S_SHIFT: if (slot_start) begin
          if (cnt == '0) begin
            tag_data_o <= 1'b0;
            state      <= (gap_bits_p == 0) ? S_IDLE : S_GAP;
          end else begin
            tag_data_o <= sr[0];
            sr         <= sr >> 1;
            cnt        <= cnt - 1'b1;
          end
        end
        S_GAP: if (slot_start) begin
          if (cnt == gap_last_lp) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_clk_gen_pearl_tag_sequencer.sv
// Bench for the tag sequencer: slot-level packet model checked every
// cycle, plus literal packet words and a reduced-width drop instance.
module tb_bsg_clk_gen_pearl_tag_sequencer;

  localparam int CD = 2;
  localparam int SLOT = 2 * CD;
  localparam int FLUSH = 16;
  localparam int GAP = 2;

  typedef struct {
    logic [2:0] id;
    logic       dnr;
    logic [2:0] len;
    logic [6:0] pl;
  } cmd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, v, dnr, ready, tag_clk, tag_data, tag_en, busy, err;
  logic [2:0] id, len;
  logic [6:0] pl;
  logic       v2, dnr2, ready2, tag_clk2, tag_data2, tag_en2, busy2, err2;
  logic [2:0] id2, len2;
  logic [4:0] pl2;

  bsg_clk_gen_pearl_tag_sequencer #(
    .tag_els_p(6), .tag_max_payload_width_p(7), .clk_div_p(CD),
    .flush_bits_p(FLUSH), .gap_bits_p(GAP)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .ready_o(ready),
    .node_id_i(id), .data_not_reset_i(dnr), .len_i(len),
    .payload_i(pl), .tag_clk_o(tag_clk), .tag_data_o(tag_data),
    .tag_en_o(tag_en), .busy_o(busy), .err_o(err)
  );

  bsg_clk_gen_pearl_tag_sequencer #(
    .tag_els_p(6), .tag_max_payload_width_p(5), .clk_div_p(CD),
    .flush_bits_p(FLUSH), .gap_bits_p(GAP)
  ) dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v2), .ready_o(ready2),
    .node_id_i(id2), .data_not_reset_i(dnr2), .len_i(len2),
    .payload_i(pl2), .tag_clk_o(tag_clk2), .tag_data_o(tag_data2),
    .tag_en_o(tag_en2), .busy_o(busy2), .err_o(err2)
  );

  cmd_t cmdq[$];
  int   c, ready_at, checks, failures, nrise, d2_err_c, d2_acc_c;
  bit   d2_live, seen_ready, prev_clk;
  bit   slotbits[int];
  bit   rise_bit[int];
  int   s0_log[$];
  int   n_log[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s c=%0d got=%0h want=%0h", nm, c, act, exp);
    end
  endtask

  task automatic model_reset();
    c = 0;
    slotbits.delete();
    rise_bit.delete();
    ready_at = FLUSH * SLOT;
    nrise = 0;
    prev_clk = 1'b0;
    seen_ready = 1'b0;
  endtask

  task automatic accept(input cmd_t k);
    bit b[$];
    int s0;
    b.push_back(1'b1);
    for (int i = 0; i < 3; i++) b.push_back(k.id[i]);
    b.push_back(k.dnr);
    for (int i = 0; i < 3; i++) b.push_back(k.len[i]);
    for (int i = 0; i < int'(k.len); i++) b.push_back(k.pl[i]);
    s0 = c / SLOT + 1;
    foreach (b[i]) slotbits[s0 + i] = b[i];
    ready_at = (s0 + b.size() + GAP) * SLOT;
    s0_log.push_back(s0);
    n_log.push_back(b.size());
  endtask

  function automatic logic [31:0] word(input int s0, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++)
      w[i] = rise_bit.exists(s0 + i) ? rise_bit[s0 + i] : 1'bx;
    return w;
  endfunction

  task automatic check_cycle();
    bit ed;
    ed = slotbits.exists(c / SLOT) ? slotbits[c / SLOT] : 1'b0;
    chk("tag_clk", 32'(tag_clk), 32'((c / CD) % 2));
    chk("tag_en", 32'(tag_en), 32'(c >= 1));
    chk("tag_data", 32'(tag_data), 32'(ed));
    chk("ready", 32'(ready), 32'(c >= ready_at));
    chk("busy", 32'(busy), 32'(c < ready_at));
    chk("err", 32'(err), 32'(0));
    if (tag_clk === 1'b1 && !prev_clk) begin
      if (nrise == 0) chk("clk_rise0", c, 2);
      else if (nrise == 1) chk("clk_rise1", c, 2 + SLOT);
      nrise++;
      rise_bit[c / SLOT] = tag_data;
    end
    prev_clk = (tag_clk === 1'b1);
    if (ready === 1'b1 && !seen_ready) begin
      seen_ready = 1'b1;
      chk("flush_len", c, FLUSH * SLOT);
    end
    if (d2_live) begin
      chk("d2_ready", 32'(ready2), 32'(c >= FLUSH * SLOT));
      chk("d2_busy", 32'(busy2), 32'(c < FLUSH * SLOT));
      chk("d2_data", 32'(tag_data2), 32'(0));
      chk("d2_err", 32'(err2), 32'(c == d2_err_c));
    end
    if (c == d2_acc_c + 1) begin
      chk("d2_accept_ready", 32'(ready2), 32'(0));
      chk("d2_accept_busy", 32'(busy2), 32'(1));
      d2_acc_c = -100;
    end
  endtask

  task automatic drive();
    if (cmdq.size() > 0) begin
      v = 1'b1;
      id = cmdq[0].id;
      dnr = cmdq[0].dnr;
      len = cmdq[0].len;
      pl = cmdq[0].pl;
    end else begin
      v = 1'b0;
      id = '0;
      dnr = 1'b0;
      len = '0;
      pl = '0;
    end
  endtask

  task automatic step();
    bit rs;
    @(negedge clk);
    check_cycle();
    if (rst_n && v && c >= ready_at && cmdq.size() > 0)
      accept(cmdq.pop_front());
    rs = rst_n;
    @(posedge clk);
    #1;
    if (!rs) model_reset();
    else c++;
    drive();
  endtask

  task automatic run_n(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((cmdq.size() > 0 || c < ready_at) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout got=%0d cycles want<%0d", n, budget);
    end
  endtask

  initial begin
    int n;
    checks = 0;
    failures = 0;
    d2_live = 1'b0;
    d2_err_c = -100;
    d2_acc_c = -100;
    rst_n = 1'b0;
    v2 = 1'b0; id2 = '0; dnr2 = 1'b0; len2 = '0; pl2 = '0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    d2_live = 1'b1;

    while (c < 70) step();

    // Over-length commands on the 5-bit-payload instance are dropped.
    v2 = 1'b1; id2 = 3'd1; dnr2 = 1'b1; len2 = 3'd6; pl2 = 5'h1F;
    d2_err_c = c + 1;
    step();
    v2 = 1'b0;
    run_n(5);
    v2 = 1'b1; len2 = 3'd7;
    d2_err_c = c + 1;
    step();
    v2 = 1'b0;
    run_n(5);
    v2 = 1'b1; len2 = 3'd5;
    d2_acc_c = c;
    step();
    v2 = 1'b0;
    d2_live = 1'b0;
    run_n(3);

    cmdq.push_back('{3'd5, 1'b1, 3'd7, 7'h55});
    drive();
    run_idle(300);
    chk("pkt1_bits", word(s0_log[0], 15), 32'h55FB);
    chk("pkt1_gap", word(s0_log[0] + 15, 2), 32'h0);

    cmdq.push_back('{3'd2, 1'b0, 3'd0, 7'h7F});
    drive();
    run_idle(300);
    chk("pkt2_bits", word(s0_log[1], 8), 32'h05);

    cmdq.push_back('{3'd1, 1'b1, 3'd3, 7'h05});
    cmdq.push_back('{3'd4, 1'b1, 3'd2, 7'h7F});
    cmdq.push_back('{3'd0, 1'b0, 3'd7, 7'h2C});
    drive();
    run_idle(600);
    chk("pkt3_bits", word(s0_log[2], 11), 32'h573);
    chk("pkt4_bits", word(s0_log[3], 10), 32'h359);
    chk("pkt5_bits", word(s0_log[4], 15), 32'h2CE1);
    chk("b2b_sep0", s0_log[3] - (s0_log[2] + n_log[2]), GAP + 1);
    chk("b2b_sep1", s0_log[4] - (s0_log[3] + n_log[3]), GAP + 1);

    cmdq.push_back('{3'd3, 1'b1, 3'd7, 7'h7F});
    drive();
    n = 0;
    while (!(s0_log.size() == 6 && c == (s0_log[5] + 4) * SLOT + 1)
           && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL shift_wait_timeout got=%0d want<300", n);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_data", 32'(tag_data), 32'(0));
    chk("rst_en", 32'(tag_en), 32'(0));
    chk("rst_clk", 32'(tag_clk), 32'(0));
    run_idle(300);

    cmdq.push_back('{3'd3, 1'b0, 3'd1, 7'h01});
    drive();
    run_idle(300);
    chk("pkt7_bits", word(s0_log[6], 9), 32'h127);
    run_n(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
